cluster_boot_sequencer: RTL and testbench

Hardware sequencer for cluster bring-up and shutdown. It sits between the SoC control register block and the cluster's reset, boot-mode and fetch-enable inputs. It replaces direct software toggling with a timed sequence: hold reset, release reset, settle, then enable fetch. Shutdown is a graceful drain with a timeout before reset is re-asserted.

---
 rtl/cluster_boot_pkg.sv | 22 ++
 rtl/cluster_boot_sequencer_cnt.sv | 29 ++
 rtl/cluster_boot_sequencer.sv | 119 +++++++++++
 tb/tb_cluster_boot_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_boot_pkg.sv
// Shared types and constants for the cluster boot sequencer.
// Holds the FSM state encoding and the counter-clamp helper.
package cluster_boot_pkg;

  localparam int CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } boot_state_e;

  // A zero delay still costs one cycle in its state.
  function automatic logic [CNT_WIDTH-1:0] clamp1(
    input logic [CNT_WIDTH-1:0] v
  );
    return (v == '0) ? CNT_WIDTH'(1) : v;
  endfunction

endpackage

// File: rtl/cluster_boot_sequencer_cnt.sv
// Loadable down-counter shared by the HOLD, SETTLE and DRAIN states.
// Stops at 1 and flags the last cycle of the timed state.
module boot_seq_cnt
  import cluster_boot_pkg::*;
#(
  parameter int W = CNT_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (load_val_i == '0) ? W'(1) : load_val_i;
    end else if (cnt_q > W'(1)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/cluster_boot_sequencer.sv
// Timed cluster bring-up (hold, release, settle, fetch) and drain.
// All outputs come straight from flops.
module cluster_boot_sequencer
  import cluster_boot_pkg::*;
#(
  parameter int CNT_WIDTH = cluster_boot_pkg::CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 en_sa_boot_i,
  input  logic [CNT_WIDTH-1:0] rst_hold_i,
  input  logic [CNT_WIDTH-1:0] settle_i,
  input  logic [CNT_WIDTH-1:0] drain_timeout_i,
  input  logic                 cluster_busy_i,
  input  logic                 cluster_eoc_i,
  output logic                 cluster_ctrl_rstn_o,
  output logic                 cluster_en_sa_boot_o,
  output logic                 cluster_fetch_en_o,
  output logic [2:0]           state_o,
  output logic                 busy_o,
  output logic                 eoc_o,
  output logic                 timeout_o
);

  boot_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] settle_q;
  logic [CNT_WIDTH-1:0] load_val;
  logic                 load, last, accept, to_set;

  boot_seq_cnt #(.W(CNT_WIDTH)) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .load_val_i (load_val),
    .last_o     (last)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    accept   = 1'b0;
    to_set   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d  = ST_HOLD;
          load     = 1'b1;
          load_val = rst_hold_i;
          accept   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (last) begin
          state_d  = ST_SETTLE;
          load     = 1'b1;
          load_val = settle_q;
        end
      end
      ST_SETTLE: begin
        if (stop_i)    state_d = ST_IDLE;
        else if (last) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d  = ST_DRAIN;
          load     = 1'b1;
          load_val = drain_timeout_i;
        end
      end
      ST_DRAIN: begin
        if (!cluster_busy_i) begin
          state_d = ST_IDLE;
        end else if (last) begin
          state_d = ST_IDLE;
          to_set  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q              <= ST_IDLE;
      settle_q             <= '0;
      cluster_ctrl_rstn_o  <= 1'b0;
      cluster_en_sa_boot_o <= 1'b0;
      cluster_fetch_en_o   <= 1'b0;
      busy_o               <= 1'b0;
      eoc_o                <= 1'b0;
      timeout_o            <= 1'b0;
    end else begin
      state_q             <= state_d;
      busy_o              <= (state_d != ST_IDLE);
      cluster_fetch_en_o  <= (state_d == ST_RUN);
      cluster_ctrl_rstn_o <= (state_d == ST_SETTLE) ||
                             (state_d == ST_RUN) ||
                             (state_d == ST_DRAIN);
      if (accept) begin
        settle_q             <= settle_i;
        cluster_en_sa_boot_o <= en_sa_boot_i;
        eoc_o                <= 1'b0;
        timeout_o            <= 1'b0;
      end else begin
        if (state_d == ST_IDLE) cluster_en_sa_boot_o <= 1'b0;
        if (state_q == ST_RUN && cluster_eoc_i) eoc_o <= 1'b1;
        if (to_set) timeout_o <= 1'b1;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_cluster_boot_sequencer.sv
// Directed bench for cluster_boot_sequencer.
// Expected values are hand-derived cycle counts.
module tb_cluster_boot_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        en_sa_boot_i = 1'b0;
  logic [15:0] rst_hold_i = '0;
  logic [15:0] settle_i = '0;
  logic [15:0] drain_timeout_i = '0;
  logic        cluster_busy_i = 1'b0;
  logic        cluster_eoc_i = 1'b0;
  logic        cluster_ctrl_rstn_o;
  logic        cluster_en_sa_boot_o;
  logic        cluster_fetch_en_o;
  logic [2:0]  state_o;
  logic        busy_o;
  logic        eoc_o;
  logic        timeout_o;

  int n_pass = 0;
  int n_total = 0;

  cluster_boot_sequencer dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .start_i              (start_i),
    .stop_i               (stop_i),
    .en_sa_boot_i         (en_sa_boot_i),
    .rst_hold_i           (rst_hold_i),
    .settle_i             (settle_i),
    .drain_timeout_i      (drain_timeout_i),
    .cluster_busy_i       (cluster_busy_i),
    .cluster_eoc_i        (cluster_eoc_i),
    .cluster_ctrl_rstn_o  (cluster_ctrl_rstn_o),
    .cluster_en_sa_boot_o (cluster_en_sa_boot_o),
    .cluster_fetch_en_o   (cluster_fetch_en_o),
    .state_o              (state_o),
    .busy_o               (busy_o),
    .eoc_o                (eoc_o),
    .timeout_o            (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
  endtask

  function automatic logic [7:0] outs();
    return {1'b0, cluster_ctrl_rstn_o, cluster_en_sa_boot_o,
            cluster_fetch_en_o, busy_o, eoc_o, timeout_o, 1'b0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step(3);
    chk("reset_outs", outs(), 8'h00);
    chk("reset_state", 8'(state_o), 8'd0);
    rst_ni = 1'b1;
    step(2);
    chk("idle_state", 8'(state_o), 8'd0);

    // bring-up with hold=4 settle=3; config changes during HOLD ignored
    rst_hold_i = 16'd4;
    settle_i = 16'd3;
    en_sa_boot_i = 1'b1;
    pulse_start();
    rst_hold_i = 16'd20;
    settle_i = 16'd20;
    en_sa_boot_i = 1'b0;
    chk("up_hold_state", 8'(state_o), 8'd1);
    chk("up_sa_boot", 8'(cluster_en_sa_boot_o), 8'd1);
    chk("up_busy", 8'(busy_o), 8'd1);
    step(3);
    chk("up_hold_rstn", 8'(cluster_ctrl_rstn_o), 8'd0);
    chk("up_hold_end", 8'(state_o), 8'd1);
    step(1);
    chk("up_rstn", 8'(cluster_ctrl_rstn_o), 8'd1);
    chk("up_settle_state", 8'(state_o), 8'd2);
    step(2);
    chk("up_fetch_early", 8'(cluster_fetch_en_o), 8'd0);
    step(1);
    chk("up_fetch", 8'(cluster_fetch_en_o), 8'd1);
    chk("up_run_state", 8'(state_o), 8'd3);

    // sticky eoc, start ignored in RUN
    cluster_eoc_i = 1'b1;
    step(1);
    cluster_eoc_i = 1'b0;
    step(3);
    chk("eoc_sticky", 8'(eoc_o), 8'd1);
    pulse_start();
    chk("run_start_ign", 8'(state_o), 8'd3);
    chk("run_start_eoc", 8'(eoc_o), 8'd1);

    // graceful stop, busy drops 4 cycles after stop
    cluster_busy_i = 1'b1;
    drain_timeout_i = 16'd10;
    pulse_stop();
    chk("drain_fetch", 8'(cluster_fetch_en_o), 8'd0);
    chk("drain_state", 8'(state_o), 8'd4);
    chk("drain_rstn", 8'(cluster_ctrl_rstn_o), 8'd1);
    step(3);
    cluster_busy_i = 1'b0;
    chk("drain_hold", 8'(state_o), 8'd4);
    step(1);
    chk("stop_idle", 8'(state_o), 8'd0);
    chk("stop_outs", outs(), 8'h04);

    // drain timeout of 6 cycles
    rst_hold_i = 16'd1;
    settle_i = 16'd1;
    en_sa_boot_i = 1'b0;
    pulse_start();
    chk("eoc_cleared", 8'(eoc_o), 8'd0);
    step(2);
    chk("to_run", 8'(state_o), 8'd3);
    cluster_busy_i = 1'b1;
    drain_timeout_i = 16'd6;
    pulse_stop();
    drain_timeout_i = 16'd1;
    step(4);
    chk("to_d4", 8'(state_o), 8'd4);
    step(1);
    chk("to_d5", 8'(state_o), 8'd4);
    chk("to_d5_flag", 8'(timeout_o), 8'd0);
    step(1);
    chk("to_idle", 8'(state_o), 8'd0);
    chk("to_flag", 8'(timeout_o), 8'd1);
    cluster_busy_i = 1'b0;

    // new start clears timeout; then abort in SETTLE
    rst_hold_i = 16'd2;
    settle_i = 16'd5;
    pulse_start();
    chk("to_cleared", 8'(timeout_o), 8'd0);
    step(2);
    chk("ab_settle", 8'(state_o), 8'd2);
    pulse_stop();
    chk("ab_state", 8'(state_o), 8'd0);
    chk("ab_outs", outs(), 8'h00);

    // zero delays, then zero drain timeout with busy high
    rst_hold_i = 16'd0;
    settle_i = 16'd0;
    pulse_start();
    chk("z_hold", 8'(state_o), 8'd1);
    chk("z_rstn0", 8'(cluster_ctrl_rstn_o), 8'd0);
    step(1);
    chk("z_rstn", 8'(cluster_ctrl_rstn_o), 8'd1);
    chk("z_fetch0", 8'(cluster_fetch_en_o), 8'd0);
    step(1);
    chk("z_fetch", 8'(cluster_fetch_en_o), 8'd1);
    cluster_busy_i = 1'b1;
    drain_timeout_i = 16'd0;
    pulse_stop();
    chk("z_drain", 8'(state_o), 8'd4);
    step(1);
    chk("z_to_idle", 8'(state_o), 8'd0);
    chk("z_to_flag", 8'(timeout_o), 8'd1);
    cluster_busy_i = 1'b0;

    // start+stop together: stop wins, nothing latched
    start_i = 1'b1;
    pulse_stop();
    start_i = 1'b0;
    chk("ss_state", 8'(state_o), 8'd0);
    chk("ss_flag", 8'(timeout_o), 8'd1);
    pulse_stop();
    chk("stop_idle_ign", 8'(state_o), 8'd0);

    // asynchronous reset in the middle of SETTLE
    rst_hold_i = 16'd1;
    settle_i = 16'd10;
    en_sa_boot_i = 1'b1;
    pulse_start();
    step(1);
    chk("rs_settle", 8'(state_o), 8'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rs_outs", outs(), 8'h00);
    chk("rs_state", 8'(state_o), 8'd0);
    step(1);
    rst_ni = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
